// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the arbiter and the SPI mem_controller.
// The slave modport is the arbiter's view; master is the requester/controller side.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic [31:0] ls_addr;
    logic [2:0]  ls_num_bytes;
    logic        ls_write;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    logic        err;

    logic        mem_start;
    logic [31:0] mem_addr;
    logic [2:0]  mem_num_bytes;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic        mem_data_fetch;
    logic        mem_done;
    logic [31:0] mem_instr;
    logic [31:0] mem_data;

    modport slave (
        input  if_req, if_addr, ls_req, ls_addr, ls_num_bytes, ls_write, ls_wdata,
               mem_done, mem_instr, mem_data,
        output if_done, if_rdata, ls_done, ls_rdata, err,
               mem_start, mem_addr, mem_num_bytes, mem_write, mem_wdata, mem_data_fetch
    );

    modport master (
        output if_req, if_addr, ls_req, ls_addr, ls_num_bytes, ls_write, ls_wdata,
               mem_done, mem_instr, mem_data,
        input  if_done, if_rdata, ls_done, ls_rdata, err,
               mem_start, mem_addr, mem_num_bytes, mem_write, mem_wdata, mem_data_fetch
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single mem_controller port between instruction fetch and load/store,
// with a start/done level handshake, a release phase and a watchdog abort.
module mem_arbiter #(
    parameter int FIXED_PRIO = 1,
    parameter int TIMEOUT    = 4096,
    parameter int TW         = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_LS, RELEASE} state_t;

    localparam bit            WD_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        state, state_d;
    logic          start_q, start_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    nbytes_q, nbytes_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          fetch_q, fetch_d;
    logic          if_done_q, if_done_d;
    logic          ls_done_q, ls_done_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   ls_rdata_q, ls_rdata_d;
    logic          err_q, err_d;
    logic          last_ls_q, last_ls_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic          pick_ls;

    function automatic logic [2:0] norm_bytes(input logic [2:0] n);
        return (n == 3'd1 || n == 3'd2) ? n : 3'd4;
    endfunction

    // On a tie, round-robin hands the grant to whichever port did not win last time
    assign pick_ls = bus.ls_req && (!bus.if_req || (FIXED_PRIO != 0) || !last_ls_q);

    always_comb begin
        state_d    = state;
        start_d    = start_q;
        addr_d     = addr_q;
        nbytes_d   = nbytes_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        fetch_d    = fetch_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        last_ls_d  = last_ls_q;
        wdog_d     = wdog_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        err_d      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    start_d = 1'b1;
                    wdog_d  = '0;
                    if (pick_ls) begin
                        addr_d    = bus.ls_addr;
                        nbytes_d  = norm_bytes(bus.ls_num_bytes);
                        write_d   = bus.ls_write;
                        wdata_d   = bus.ls_wdata;
                        fetch_d   = !bus.ls_write;
                        last_ls_d = 1'b1;
                        state_d   = GRANT_LS;
                    end else begin
                        addr_d    = bus.if_addr;
                        nbytes_d  = 3'd4;
                        write_d   = 1'b0;
                        wdata_d   = '0;
                        fetch_d   = 1'b0;
                        last_ls_d = 1'b0;
                        state_d   = GRANT_IF;
                    end
                end
            end
            GRANT_IF, GRANT_LS: begin
                wdog_d = wdog_q + 1'b1;
                // A real completion takes precedence over a coincident watchdog expiry
                if (bus.mem_done || (WD_EN && wdog_q == WD_LAST)) begin
                    start_d = 1'b0;
                    write_d = 1'b0;
                    err_d   = !bus.mem_done;
                    state_d = RELEASE;
                    if (state == GRANT_IF) begin
                        if_done_d = 1'b1;
                        if (bus.mem_done) if_rdata_d = bus.mem_instr;
                    end else begin
                        ls_done_d = 1'b1;
                        if (bus.mem_done && fetch_q) ls_rdata_d = bus.mem_data;
                    end
                end
            end
            RELEASE: begin
                if (!bus.mem_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            addr_q     <= '0;
            nbytes_q   <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            fetch_q    <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            err_q      <= 1'b0;
            last_ls_q  <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state      <= state_d;
            start_q    <= start_d;
            addr_q     <= addr_d;
            nbytes_q   <= nbytes_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            fetch_q    <= fetch_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            err_q      <= err_d;
            last_ls_q  <= last_ls_d;
            wdog_q     <= wdog_d;
        end
    end

    assign bus.mem_start      = start_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_num_bytes  = nbytes_q;
    assign bus.mem_write      = write_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_data_fetch = fetch_q;
    assign bus.if_done        = if_done_q;
    assign bus.ls_done        = ls_done_q;
    assign bus.if_rdata       = if_rdata_q;
    assign bus.ls_rdata       = ls_rdata_q;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: dut_a uses fixed LS priority and the default watchdog,
// dut_b uses round-robin and a 16-cycle watchdog. Each has a simple controller model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if ia ();
    mem_arbiter_if ib ();

    mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(4096), .TW(13)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(16),   .TW(5))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    int dly_a, dly_b, cnt_a, cnt_b;
    int total = 0;
    int bad   = 0;
    int n;

    // Controller model: raise done dly cycles after start is seen, drop it once start falls
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= 0; ia.mem_done <= 1'b0;
        end else if (!ia.mem_start) begin
            cnt_a <= 0; ia.mem_done <= 1'b0;
        end else if (!ia.mem_done) begin
            if (cnt_a == dly_a - 1) ia.mem_done <= 1'b1;
            cnt_a <= cnt_a + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_b <= 0; ib.mem_done <= 1'b0;
        end else if (!ib.mem_start) begin
            cnt_b <= 0; ib.mem_done <= 1'b0;
        end else if (!ib.mem_done) begin
            if (cnt_b == dly_b - 1) ib.mem_done <= 1'b1;
            cnt_b <= cnt_b + 1;
        end
    end

    logic [5:0] ev;
    assign ev = {ib.err, ib.ls_done, ib.if_done, ia.err, ia.ls_done, ia.if_done};
    localparam logic [5:0] A_IF = 6'b000001, A_LS = 6'b000010, A_ANY = 6'b000011;
    localparam logic [5:0] B_IF = 6'b001000, B_LS = 6'b010000, B_ANY = 6'b011000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ev(input string tag, input logic [5:0] mask, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (((ev & mask) == 6'd0) && cyc < budget);
        chk(tag, 32'((ev & mask) != 6'd0), 32'd1);
    endtask

    logic ls_first [4];

    initial begin
        rst_n = 1'b0;
        dly_a = 40; dly_b = 3;
        ia.if_req = 0; ia.if_addr = 0; ia.ls_req = 0; ia.ls_addr = 0; ia.ls_num_bytes = 0;
        ia.ls_write = 0; ia.ls_wdata = 0; ia.mem_instr = 0; ia.mem_data = 0;
        ib.if_req = 0; ib.if_addr = 0; ib.ls_req = 0; ib.ls_addr = 0; ib.ls_num_bytes = 0;
        ib.ls_write = 0; ib.ls_wdata = 0; ib.mem_instr = 0; ib.mem_data = 0;
        repeat (3) @(negedge clk);
        chk("rst_mem_start", ia.mem_start, 0);
        chk("rst_if_done", ia.if_done, 0);
        chk("rst_ls_done", ia.ls_done, 0);
        chk("rst_err", ia.err, 0);
        chk("rst_mem_addr", ia.mem_addr, 0);
        chk("rst_if_rdata", ia.if_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: IF only, 40-cycle controller latency
        ia.mem_instr = 32'h0050_0093;
        ia.if_req = 1; ia.if_addr = 32'h100;
        @(negedge clk);
        chk("t1_start", ia.mem_start, 1);
        chk("t1_addr", ia.mem_addr, 32'h100);
        chk("t1_nbytes", ia.mem_num_bytes, 4);
        chk("t1_write", ia.mem_write, 0);
        chk("t1_fetch", ia.mem_data_fetch, 0);
        wait_ev("t1_if_done_seen", A_ANY, 100, n);
        chk("t1_latency", n, 41);
        chk("t1_if_done", ia.if_done, 1);
        chk("t1_rdata", ia.if_rdata, 32'h0050_0093);
        chk("t1_start_low", ia.mem_start, 0);
        chk("t1_err", ia.err, 0);
        ia.if_req = 0;
        @(negedge clk);
        chk("t1_done_pulse", ia.if_done, 0);
        repeat (3) @(negedge clk);

        // 2: IF and LS load together, fixed priority -> LS first
        dly_a = 5;
        ia.mem_data = 32'h1234_5678; ia.mem_instr = 32'hCAFE_F00D;
        ia.if_req = 1; ia.if_addr = 32'h200;
        ia.ls_req = 1; ia.ls_addr = 32'h300; ia.ls_write = 0; ia.ls_num_bytes = 4;
        @(negedge clk);
        chk("t2_addr_ls", ia.mem_addr, 32'h300);
        chk("t2_fetch", ia.mem_data_fetch, 1);
        wait_ev("t2_first_seen", A_ANY, 50, n);
        chk("t2_first_ls", ia.ls_done, 1);
        chk("t2_first_not_if", ia.if_done, 0);
        chk("t2_ls_rdata", ia.ls_rdata, 32'h1234_5678);
        ia.ls_req = 0;
        wait_ev("t2_second_seen", A_ANY, 50, n);
        chk("t2_second_if", ia.if_done, 1);
        chk("t2_second_not_ls", ia.ls_done, 0);
        chk("t2_if_addr", ia.mem_addr, 32'h200);
        chk("t2_if_rdata", ia.if_rdata, 32'hCAFE_F00D);
        chk("t2_ls_rdata_kept", ia.ls_rdata, 32'h1234_5678);
        ia.if_req = 0;
        repeat (3) @(negedge clk);

        // 3: round-robin, both held for 4 transfers -> LS, IF, LS, IF
        ib.mem_data = 32'h0D0D_0D0D; ib.mem_instr = 32'h1111_1111;
        ib.if_req = 1; ib.if_addr = 32'h10;
        ib.ls_req = 1; ib.ls_addr = 32'h20; ib.ls_write = 0; ib.ls_num_bytes = 4;
        ls_first[0] = 1; ls_first[1] = 0; ls_first[2] = 1; ls_first[3] = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ev("t3_done_seen", B_ANY, 50, n);
            chk($sformatf("t3_order%0d", k), ib.ls_done, 32'(ls_first[k]));
            chk($sformatf("t3_err%0d", k), ib.err, 0);
        end
        ib.if_req = 0; ib.ls_req = 0;
        chk("t3_ls_rdata", ib.ls_rdata, 32'h0D0D_0D0D);
        chk("t3_if_rdata", ib.if_rdata, 32'h1111_1111);
        repeat (3) @(negedge clk);

        // 4: LS store, halfword
        dly_a = 6;
        ia.ls_req = 1; ia.ls_addr = 32'h400; ia.ls_write = 1; ia.ls_num_bytes = 2;
        ia.ls_wdata = 32'hBEEF_0000;
        @(negedge clk);
        chk("t4_write", ia.mem_write, 1);
        chk("t4_nbytes", ia.mem_num_bytes, 2);
        chk("t4_wdata", ia.mem_wdata, 32'hBEEF_0000);
        chk("t4_fetch", ia.mem_data_fetch, 0);
        repeat (3) @(negedge clk);
        chk("t4_write_held", ia.mem_write, 1);
        chk("t4_wdata_held", ia.mem_wdata, 32'hBEEF_0000);
        wait_ev("t4_ls_done_seen", A_LS, 50, n);
        chk("t4_nbytes_held", ia.mem_num_bytes, 2);
        chk("t4_write_cleared", ia.mem_write, 0);
        chk("t4_ls_rdata_kept", ia.ls_rdata, 32'h1234_5678);
        ia.ls_req = 0;
        repeat (3) @(negedge clk);

        // 4b: out-of-range byte count is treated as a word
        ia.mem_data = 32'h5A5A_5A5A;
        ia.ls_req = 1; ia.ls_addr = 32'h404; ia.ls_write = 0; ia.ls_num_bytes = 3;
        @(negedge clk);
        chk("t4b_nbytes", ia.mem_num_bytes, 4);
        wait_ev("t4b_ls_done_seen", A_LS, 50, n);
        chk("t4b_ls_rdata", ia.ls_rdata, 32'h5A5A_5A5A);
        ia.ls_req = 0;
        repeat (3) @(negedge clk);

        // 5: watchdog abort after 16 cycles, then a normal LS transfer
        dly_b = 1000;
        ib.mem_instr = 32'h2222_2222;
        ib.if_req = 1; ib.if_addr = 32'h500;
        @(negedge clk);
        chk("t5_start", ib.mem_start, 1);
        wait_ev("t5_if_done_seen", B_IF, 100, n);
        chk("t5_abort_cycles", n, 16);
        chk("t5_err", ib.err, 1);
        chk("t5_start_low", ib.mem_start, 0);
        chk("t5_if_rdata_kept", ib.if_rdata, 32'h1111_1111);
        dly_b = 3;
        ib.mem_data = 32'h3333_3333;
        ib.if_req = 0;
        ib.ls_req = 1; ib.ls_addr = 32'h600; ib.ls_write = 0; ib.ls_num_bytes = 1;
        @(negedge clk);
        chk("t5_err_pulse", ib.err, 0);
        wait_ev("t5_ls_done_seen", B_LS, 50, n);
        chk("t5_ls_err", ib.err, 0);
        chk("t5_ls_rdata", ib.ls_rdata, 32'h3333_3333);
        chk("t5_ls_nbytes", ib.mem_num_bytes, 1);
        ib.ls_req = 0;
        repeat (3) @(negedge clk);

        // 6: asynchronous reset in the middle of a grant
        dly_a = 40;
        ia.mem_instr = 32'h0A0A_0A0A;
        ia.if_req = 1; ia.if_addr = 32'h700;
        @(negedge clk);
        chk("t6_start", ia.mem_start, 1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_start_async", ia.mem_start, 0);
        chk("t6_no_done", ia.if_done, 0);
        @(negedge clk);
        chk("t6_no_done_rst", ia.if_done, 0);
        chk("t6_rdata_rst", ia.if_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_regrant", ia.mem_start, 1);
        chk("t6_regrant_addr", ia.mem_addr, 32'h700);
        wait_ev("t6_if_done_seen", A_ANY, 100, n);
        chk("t6_latency", n, 41);
        chk("t6_if_done", ia.if_done, 1);
        chk("t6_if_rdata", ia.if_rdata, 32'h0A0A_0A0A);
        ia.if_req = 0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
